load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Core-side initiator for the data-memory interface; sits between the EX stage and the data memory.
- Takes one load/store per request from the pipeline and drives word address, byte enables and lane-shifted write data over a req/gnt/rvalid handshake.
- Aligns and sign/zero-extends returned load data and holds the pipeline stalled until the access completes.
- Detects misaligned accesses and stores to the print MMIO address.

Parameters:
- ADDR_W, 32, byte-address width.
- PRINT_ADDR, 32'h3800040c, byte address of the print/console MMIO word.
- TIMEOUT_CYCLES, 255, wait-state limit; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous active-low reset.
- EX_VALID  in  1  access request from EX this cycle.
- EX_MRD  in  1  load.
- EX_MWRT  in  1  store; EX_MRD and EX_MWRT are never both 1.
- EX_FUNC3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- EX_ADDR  in  ADDR_W  byte address.
- EX_WDATA  in  32  store data, right-aligned.
- STALL  out  1  pipeline must hold EX inputs stable.
- WB_VALID  out  1  one-cycle completion pulse.
- WB_DATA  out  32  extended load data; 0 for stores.
- MISALIGN  out  1  one-cycle pulse, access rejected.
- BUS_ERR  out  1  one-cycle pulse, timeout abort; tied 0 without the optional feature.
- PRINT_EN  out  1  one-cycle pulse, store to PRINT_ADDR accepted.
- PRINT_VAL  out  32  EX_WDATA registered with PRINT_EN.
- MEM_REQ  out  1  request valid.
- MEM_WE  out  1  1 = write.
- MEM_ADDR  out  ADDR_W-2  word address, EX_ADDR>>2.
- MEM_BE  out  4  byte enables.
- MEM_WDATA  out  32  lane-replicated store data.
- MEM_GNT  in  1  request accepted.
- MEM_RVALID  in  1  read data valid.
- MEM_RDATA  in  32  read word.

Behaviour:
- Reset: all outputs 0. Registers: state IDLE, captured funct3/offset 0, timeout count 0.
- FSM states and transitions:
  - IDLE: EX_VALID & (EX_MRD | EX_MWRT).
    - Misaligned (H with addr[0]=1, W with addr[1:0]!=0): MISALIGN pulses next cycle, no MEM_REQ, back to IDLE.
    - Otherwise go to REQ; MEM_* are registered from EX inputs. Capture funct3 and addr[1:0].
  - REQ: MEM_REQ=1 and MEM_* held stable until MEM_GNT.
    - On gnt with a store: go to DONE.
    - On gnt with a load: go to WAIT.
  - WAIT: MEM_REQ=0.
    - MEM_RVALID: latch extended data into WB_DATA and go to DONE.
    - MEM_RVALID in the same cycle as MEM_GNT (zero-wait memory) is accepted in REQ: go straight to DONE.
  - DONE: WB_VALID=1 for one cycle, then IDLE.
- STALL = (state!=IDLE) | (EX_VALID & access & state==IDLE), deasserted in the DONE cycle. This gives 3-cycle minimum store latency (IDLE→REQ→DONE) and 3-cycle minimum load latency with zero-wait memory.
- Byte enables:
  - B: 0001<<off.
  - H: 0011<<off.
  - W: 1111.
- Write data:
  - B: byte replicated x4.
  - H: halfword replicated x2.
  - W: as-is.
- Load extraction:
  - B/BU: byte off → sign/zero-extend.
  - H/HU: halfword off[1] → sign/zero-extend.
  - W: whole word.
  - Unsupported funct3 (011, 110, 111): treated as W for loads; no request for stores, complete with WB_VALID and no error.
- PRINT_EN: pulses in the DONE cycle of a store whose word address equals PRINT_ADDR>>2.
- Stray handshakes: MEM_GNT/MEM_RVALID outside REQ/WAIT are ignored.
- EX_VALID while busy is ignored, since the pipeline is stalled.
- Reset mid-access: immediate return to IDLE, MEM_REQ drops; any later rvalid is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: 8-bit counter clears on entry to REQ or WAIT and increments each cycle spent there. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse BUS_ERR, WB_VALID=0, STALL released.
- Undefined: no counter; the unit waits forever; BUS_ERR tied 0.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding IDLE/REQ/WAIT/DONE.
  - Default PRINT_ADDR.
- One natural sub-module: lsu_load_align, combinational: rdata, funct3, offset → extended word.

Test Plan:
- SB 0xA5 at addr 0x102, gnt same cycle → MEM_ADDR=0x40, BE=0100, WDATA=0xA5A5A5A5, WB_VALID on cycle 3, STALL high cycles 1-2.
- LB addr 0x103, MEM_RDATA=0x80123456, rvalid 2 cycles after gnt → WB_DATA=0xFFFFFF80; the same access as LBU → 0x00000080.
- LH at 0x201 → MISALIGN pulse, MEM_REQ never asserted; LW at 0x202 → MISALIGN.
- SW 0x0000002A to 0x3800040c → PRINT_EN for one cycle with PRINT_VAL=0x2A; SW to 0x38000410 → no PRINT_EN.
- RESET_N low while in WAIT, then rvalid after release → all outputs 0, no WB_VALID.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt held low → BUS_ERR pulse after 4 REQ cycles, STALL deasserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads/stores (F3_*)
//   - FSM state encoding (lsu_state_e)
//   - default byte address of the print/console MMIO word
//   - small funct3 decode helpers
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] LSU_PRINT_ADDR = 32'h3800_040c;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StDone = 2'd3
   } lsu_state_e;

   function automatic logic f3_is_byte(logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_BU);
   endfunction

   function automatic logic f3_is_half(logic [2:0] f3);
      return (f3 == F3_H) || (f3 == F3_HU);
   endfunction

   // 011/110/111 are not RV32I load/store widths.
   function automatic logic f3_unsupported(logic [2:0] f3);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data aligner.
// Ports:
//   rdata_i   32  raw word returned by the data memory
//   funct3_i   3  captured load funct3
//   offset_i   2  captured byte offset within the word
//   data_o    32  selected byte/halfword, sign- or zero-extended; whole word otherwise
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (offset_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
      endcase

      half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      // Unsupported encodings fall through to a full-word load.
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the data-memory req/gnt/rvalid interface.
// Takes one load/store from EX, drives word address, byte enables and lane-replicated
// store data, aligns/extends load data, and stalls the pipeline until completion.
// Ports:
//   CLK, RESET_N                     clock, asynchronous active-low reset
//   EX_VALID/EX_MRD/EX_MWRT          access request, load, store
//   EX_FUNC3, EX_ADDR, EX_WDATA      width/sign, byte address, right-aligned store data
//   STALL                            pipeline must hold EX inputs
//   WB_VALID, WB_DATA                completion pulse, extended load data (0 for stores)
//   MISALIGN, BUS_ERR                rejected-access pulse, timeout-abort pulse
//   PRINT_EN, PRINT_VAL              store to the print MMIO word and its data
//   MEM_REQ/WE/ADDR/BE/WDATA         request side of the memory interface
//   MEM_GNT, MEM_RVALID, MEM_RDATA   response side of the memory interface
// Build option: define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES cycles
// in REQ or WAIT; without it the unit waits forever and BUS_ERR is tied low.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] PRINT_ADDR     = ADDR_W'(LSU_PRINT_ADDR),
   parameter int unsigned       TIMEOUT_CYCLES = 255
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              EX_VALID,
   input  logic              EX_MRD,
   input  logic              EX_MWRT,
   input  logic [2:0]        EX_FUNC3,
   input  logic [ADDR_W-1:0] EX_ADDR,
   input  logic [31:0]       EX_WDATA,
   output logic              STALL,
   output logic              WB_VALID,
   output logic [31:0]       WB_DATA,
   output logic              MISALIGN,
   output logic              BUS_ERR,
   output logic              PRINT_EN,
   output logic [31:0]       PRINT_VAL,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-3:0] MEM_ADDR,
   output logic [3:0]        MEM_BE,
   output logic [31:0]       MEM_WDATA,
   input  logic              MEM_GNT,
   input  logic              MEM_RVALID,
   input  logic [31:0]       MEM_RDATA
);

   lsu_state_e        state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic              we_q, we_d;
   logic [ADDR_W-3:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              print_hit_q, print_hit_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              misalign_q, misalign_d;
   logic              print_en_q, print_en_d;
   logic [31:0]       print_val_q, print_val_d;

   logic        access, is_b, is_h, unsup_st, misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] load_data;
   logic        abort;
   logic        mem_req;

   lsu_load_align u_load_align (
      .rdata_i  (MEM_RDATA),
      .funct3_i (funct3_q),
      .offset_i (off_q),
      .data_o   (load_data)
   );

   // Request decode from the EX inputs.
   always_comb begin
      access   = EX_VALID & (EX_MRD | EX_MWRT);
      is_b     = f3_is_byte(EX_FUNC3);
      is_h     = f3_is_half(EX_FUNC3);
      // Unsupported-width stores complete silently without touching memory.
      unsup_st = EX_MWRT & f3_unsupported(EX_FUNC3);
      misaligned = ~unsup_st & ((is_h & EX_ADDR[0]) |
                                (~is_b & ~is_h & (EX_ADDR[1:0] != 2'b00)));
      if (is_b) begin
         be_new    = 4'b0001 << EX_ADDR[1:0];
         wdata_new = {4{EX_WDATA[7:0]}};
      end else if (is_h) begin
         be_new    = 4'b0011 << EX_ADDR[1:0];
         wdata_new = {2{EX_WDATA[15:0]}};
      end else begin
         be_new    = 4'b1111;
         wdata_new = EX_WDATA;
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       bus_err_q, bus_err_d;

   // Abort on the last allowed cycle unless the awaited handshake arrives in it.
   assign abort = (tmo_cnt_q == TMO_LAST) &
                  (((state_q == StReq) & ~MEM_GNT) | ((state_q == StWait) & ~MEM_RVALID));

   always_comb begin
      bus_err_d = abort;
      // Clears on every entry to REQ/WAIT, counts while the state is held.
      tmo_cnt_d = 8'd0;
      if (((state_q == StReq) || (state_q == StWait)) && (state_d == state_q)) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tmo_cnt_q <= 8'd0;
         bus_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign BUS_ERR = bus_err_q;
`else
   assign abort   = 1'b0;
   assign BUS_ERR = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      we_d        = we_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      print_hit_d = print_hit_q;
      print_val_d = print_val_q;
      wb_data_d   = 32'h0;
      misalign_d  = 1'b0;
      print_en_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (access) begin
               if (misaligned) begin
                  misalign_d = 1'b1;
               end else if (unsup_st) begin
                  state_d = StDone;
               end else begin
                  state_d     = StReq;
                  funct3_d    = EX_FUNC3;
                  off_d       = EX_ADDR[1:0];
                  we_d        = EX_MWRT;
                  addr_d      = EX_ADDR[ADDR_W-1:2];
                  be_d        = be_new;
                  wdata_d     = EX_MWRT ? wdata_new : 32'h0;
                  print_hit_d = EX_MWRT & (EX_ADDR[ADDR_W-1:2] == PRINT_ADDR[ADDR_W-1:2]);
               end
            end
         end
         StReq: begin
            if (abort) begin
               state_d = StIdle;
            end else if (MEM_GNT) begin
               if (we_q) begin
                  state_d    = StDone;
                  print_en_d = print_hit_q;
                  // EX_WDATA is still held by the stall; keep it unreplicated.
                  if (print_hit_q) begin
                     print_val_d = EX_WDATA;
                  end
               end else if (MEM_RVALID) begin
                  state_d   = StDone;
                  wb_data_d = load_data;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (abort) begin
               state_d = StIdle;
            end else if (MEM_RVALID) begin
               state_d   = StDone;
               wb_data_d = load_data;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         funct3_q    <= 3'h0;
         off_q       <= 2'h0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
         print_hit_q <= 1'b0;
         wb_data_q   <= 32'h0;
         misalign_q  <= 1'b0;
         print_en_q  <= 1'b0;
         print_val_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         print_hit_q <= print_hit_d;
         wb_data_q   <= wb_data_d;
         misalign_q  <= misalign_d;
         print_en_q  <= print_en_d;
         print_val_q <= print_val_d;
      end
   end

   // Memory-side fields are only driven while a request is outstanding.
   assign mem_req   = (state_q == StReq);
   assign MEM_REQ   = mem_req;
   assign MEM_WE    = mem_req & we_q;
   assign MEM_ADDR  = mem_req ? addr_q : '0;
   assign MEM_BE    = mem_req ? be_q : 4'h0;
   assign MEM_WDATA = mem_req ? wdata_q : 32'h0;

   // Released in DONE so the pipeline advances on the completion edge.
   assign STALL     = (state_q == StReq) | (state_q == StWait) | ((state_q == StIdle) & access);
   assign WB_VALID  = (state_q == StDone);
   assign WB_DATA   = wb_data_q;
   assign MISALIGN  = misalign_q;
   assign PRINT_EN  = print_en_q;
   assign PRINT_VAL = print_val_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses, a per-cycle compare
// against expectations derived from a transaction-level model, plus literal checks.
module tb_load_store_unit;

   localparam logic [31:0] PRINT_A = 32'h3800_040c;

   logic        CLK, RESET_N;
   logic        EX_VALID, EX_MRD, EX_MWRT;
   logic [2:0]  EX_FUNC3;
   logic [31:0] EX_ADDR, EX_WDATA;
   logic        STALL, WB_VALID, MISALIGN, BUS_ERR, PRINT_EN;
   logic [31:0] WB_DATA, PRINT_VAL;
   logic        MEM_REQ, MEM_WE, MEM_GNT, MEM_RVALID;
   logic [29:0] MEM_ADDR;
   logic [3:0]  MEM_BE;
   logic [31:0] MEM_WDATA, MEM_RDATA;

   load_store_unit #(
      .ADDR_W         (32),
      .PRINT_ADDR     (PRINT_A),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .EX_VALID   (EX_VALID),
      .EX_MRD     (EX_MRD),
      .EX_MWRT    (EX_MWRT),
      .EX_FUNC3   (EX_FUNC3),
      .EX_ADDR    (EX_ADDR),
      .EX_WDATA   (EX_WDATA),
      .STALL      (STALL),
      .WB_VALID   (WB_VALID),
      .WB_DATA    (WB_DATA),
      .MISALIGN   (MISALIGN),
      .BUS_ERR    (BUS_ERR),
      .PRINT_EN   (PRINT_EN),
      .PRINT_VAL  (PRINT_VAL),
      .MEM_REQ    (MEM_REQ),
      .MEM_WE     (MEM_WE),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_BE     (MEM_BE),
      .MEM_WDATA  (MEM_WDATA),
      .MEM_GNT    (MEM_GNT),
      .MEM_RVALID (MEM_RVALID),
      .MEM_RDATA  (MEM_RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Expected outputs for the current cycle.
   logic        e_stall, e_wbv, e_mis, e_berr, e_pen, e_req, e_we;
   logic [31:0] e_wbd, e_wd, e_pval;
   logic [29:0] e_addr;
   logic [3:0]  e_be;
   bit          chk_en = 1'b0;

   // Observations used by the literal checks.
   int          n_req_cyc = 0, n_wbv = 0, n_print = 0, n_mis = 0;
   logic [29:0] last_addr;
   logic [3:0]  last_be;
   logic [31:0] last_wd, last_wbd, last_pval;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---- transaction-level model ----
   function automatic int m_nb(logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit m_unsup(logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic bit m_mis(logic [2:0] f3, logic [31:0] a);
      return (a % m_nb(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
      logic [31:0] m;
      m = ((32'd1 << m_nb(f3)) - 32'd1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] wd);
      case (m_nb(f3))
         1:       return (wd & 32'hFF) * 32'h0101_0101;
         2:       return (wd & 32'hFFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_ld(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * (a % 4));
      if (m_nb(f3) == 1) begin
         v = v & 32'hFF;
         if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end else if (m_nb(f3) == 2) begin
         v = v & 32'hFFFF;
         if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   // ---- per-cycle compare ----
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("STALL",     32'(STALL),     32'(e_stall));
         chk("WB_VALID",  32'(WB_VALID),  32'(e_wbv));
         chk("WB_DATA",   WB_DATA,        e_wbd);
         chk("MISALIGN",  32'(MISALIGN),  32'(e_mis));
         chk("BUS_ERR",   32'(BUS_ERR),   32'(e_berr));
         chk("PRINT_EN",  32'(PRINT_EN),  32'(e_pen));
         chk("PRINT_VAL", PRINT_VAL,      e_pval);
         chk("MEM_REQ",   32'(MEM_REQ),   32'(e_req));
         chk("MEM_WE",    32'(MEM_WE),    32'(e_we));
         chk("MEM_ADDR",  32'(MEM_ADDR),  32'(e_addr));
         chk("MEM_BE",    32'(MEM_BE),    32'(e_be));
         chk("MEM_WDATA", MEM_WDATA,      e_wd);
      end
      if (MEM_REQ === 1'b1) begin
         n_req_cyc++;
         last_addr = MEM_ADDR;
         last_be   = MEM_BE;
         last_wd   = MEM_WDATA;
      end
      if (WB_VALID === 1'b1) begin
         n_wbv++;
         last_wbd = WB_DATA;
      end
      if (PRINT_EN === 1'b1) begin
         n_print++;
         last_pval = PRINT_VAL;
      end
      if (MISALIGN === 1'b1) n_mis++;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_exp();
      e_stall = 1'b0; e_wbv = 1'b0; e_mis = 1'b0; e_berr = 1'b0; e_pen = 1'b0;
      e_req = 1'b0; e_we = 1'b0; e_wbd = 32'h0; e_wd = 32'h0; e_addr = 30'h0; e_be = 4'h0;
   endtask

   // One access; gdly = REQ cycles before gnt, rdly = cycles from gnt to rvalid.
   task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gdly, input int rdly,
                         input logic [31:0] rd);
      bit unsup, mis, hit;
      unsup = !ld && m_unsup(f3);
      mis   = !unsup && m_mis(f3, a);
      hit   = !ld && !unsup && ((a >> 2) == (PRINT_A >> 2));
      clr_exp();
      EX_VALID = 1'b1; EX_MRD = ld; EX_MWRT = !ld; EX_FUNC3 = f3;
      EX_ADDR = a; EX_WDATA = wd; MEM_RDATA = rd;
      e_stall = 1'b1;
      step();
      if (mis) begin
         EX_VALID = 1'b0;
         clr_exp(); e_mis = 1'b1;
         step();
      end else if (unsup) begin
         clr_exp(); e_wbv = 1'b1;
         step();
      end else begin
         for (int i = 0; i <= gdly; i++) begin
            clr_exp();
            e_stall = 1'b1; e_req = 1'b1; e_we = !ld; e_addr = a[31:2];
            e_be = m_be(f3, a); e_wd = ld ? 32'h0 : m_wd(f3, wd);
            MEM_GNT    = (i == gdly);
            MEM_RVALID = ld && (i == gdly) && (rdly == 0);
            step();
         end
         MEM_GNT = 1'b0;
         if (ld) begin
            for (int j = 1; j <= rdly; j++) begin
               clr_exp(); e_stall = 1'b1;
               MEM_RVALID = (j == rdly);
               step();
            end
         end
         MEM_RVALID = 1'b0;
         clr_exp(); e_wbv = 1'b1;
         if (ld) e_wbd = m_ld(f3, a, rd);
         if (hit) begin
            e_pen = 1'b1; e_pval = wd;
         end
         step();
      end
      EX_VALID = 1'b0;
      clr_exp();
   endtask

   int base;

   initial begin
      RESET_N = 1'b1; EX_VALID = 1'b0; EX_MRD = 1'b0; EX_MWRT = 1'b0; EX_FUNC3 = 3'h0;
      EX_ADDR = 32'h0; EX_WDATA = 32'h0; MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = 32'h0;
      clr_exp(); e_pval = 32'h0;
      #2 RESET_N = 1'b0;
      chk_en = 1'b1;
      step();
      step();
      RESET_N = 1'b1;
      step();

      // SB 0xA5 @0x102, zero-wait grant.
      access(1'b0, 3'b000, 32'h102, 32'h0000_00A5, 0, 0, 32'h0);
      chk("sb_addr",  32'(last_addr), 32'h40);
      chk("sb_be",    32'(last_be),   32'h4);
      chk("sb_wdata", last_wd,        32'hA5A5_A5A5);

      // LB / LBU @0x103, rvalid two cycles after gnt.
      access(1'b1, 3'b000, 32'h103, 32'h0, 0, 2, 32'h8012_3456);
      chk("lb_data", last_wbd, 32'hFFFF_FF80);
      access(1'b1, 3'b100, 32'h103, 32'h0, 0, 2, 32'h8012_3456);
      chk("lbu_data", last_wbd, 32'h0000_0080);

      // Misaligned LH and LW.
      base = n_req_cyc;
      access(1'b1, 3'b001, 32'h201, 32'h0, 0, 0, 32'h0);
      access(1'b1, 3'b010, 32'h202, 32'h0, 0, 0, 32'h0);
      chk("mis_no_req", 32'(n_req_cyc - base), 32'd0);
      chk("mis_pulses", 32'(n_mis), 32'd2);

      // Print MMIO store, then a store to the next word.
      access(1'b0, 3'b010, 32'h3800_040c, 32'h0000_002A, 1, 0, 32'h0);
      access(1'b0, 3'b010, 32'h3800_0410, 32'h0000_0077, 0, 0, 32'h0);

      // SH upper half with wait-stated grant.
      access(1'b0, 3'b001, 32'h12, 32'h1234_BEEF, 2, 0, 32'h0);
      chk("sh_be",    32'(last_be), 32'hC);
      chk("sh_wdata", last_wd,      32'hBEEF_BEEF);

      // Halfword and word loads, including zero-wait rvalid with gnt.
      access(1'b1, 3'b001, 32'h106, 32'h0, 1, 1, 32'h8001_7FFF);
      chk("lh_data", last_wbd, 32'hFFFF_8001);
      access(1'b1, 3'b101, 32'h106, 32'h0, 0, 0, 32'h8001_7FFF);
      chk("lhu_data", last_wbd, 32'h0000_8001);
      access(1'b1, 3'b010, 32'h200, 32'h0, 1, 0, 32'hDEAD_BEEF);
      chk("lw_data", last_wbd, 32'hDEAD_BEEF);
      access(1'b1, 3'b000, 32'h301, 32'h0, 0, 1, 32'h0000_FF00);
      access(1'b1, 3'b000, 32'h300, 32'h0, 0, 0, 32'h1234_567F);

      // Unsupported widths: store completes without a request, load acts as LW.
      base = n_req_cyc;
      access(1'b0, 3'b011, 32'h3800_040c, 32'h0000_0055, 0, 0, 32'h0);
      chk("unsup_st_no_req", 32'(n_req_cyc - base), 32'd0);
      access(1'b1, 3'b110, 32'h300, 32'h0, 0, 1, 32'hCAFE_F00D);
      chk("unsup_ld_data", last_wbd, 32'hCAFE_F00D);
      chk("print_count", 32'(n_print), 32'd1);
      chk("print_val",   last_pval,    32'h0000_002A);

      // Stray handshakes while idle.
      clr_exp();
      MEM_GNT = 1'b1; MEM_RVALID = 1'b1;
      step();
      MEM_GNT = 1'b0; MEM_RVALID = 1'b0;
      step();

`ifdef LSU_TIMEOUT_EN
      // Grant never arrives: abort after four REQ cycles.
      clr_exp();
      EX_VALID = 1'b1; EX_MRD = 1'b1; EX_MWRT = 1'b0; EX_FUNC3 = 3'b010; EX_ADDR = 32'h400;
      e_stall = 1'b1;
      step();
      base = n_req_cyc;
      for (int i = 0; i < 4; i++) begin
         clr_exp(); e_stall = 1'b1; e_req = 1'b1; e_addr = 30'h100; e_be = 4'hF;
         step();
      end
      EX_VALID = 1'b0;
      clr_exp(); e_berr = 1'b1;
      step();
      clr_exp();
      step();
      chk("tmo_req_cycles", 32'(n_req_cyc - base), 32'd4);
`endif

      // Reset while in WAIT, then a late rvalid.
      clr_exp();
      EX_VALID = 1'b1; EX_MRD = 1'b1; EX_MWRT = 1'b0; EX_FUNC3 = 3'b010; EX_ADDR = 32'h500;
      e_stall = 1'b1;
      step();
      clr_exp(); e_stall = 1'b1; e_req = 1'b1; e_addr = 30'h140; e_be = 4'hF;
      MEM_GNT = 1'b1;
      step();
      MEM_GNT = 1'b0;
      clr_exp(); e_stall = 1'b1;
      step();
      base = n_wbv;
      RESET_N = 1'b0; EX_VALID = 1'b0;
      clr_exp(); e_pval = 32'h0;
      step();
      RESET_N = 1'b1;
      MEM_RVALID = 1'b1; MEM_RDATA = 32'h1234_5678;
      step();
      MEM_RVALID = 1'b0;
      step();
      chk("rst_no_wb", 32'(n_wbv - base), 32'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
